// File: rtl/matrix_seq_pkg.sv
// rtl/matrix_seq_pkg.sv - shared state/pattern types and width helper for the matrix frame sequencer
package matrix_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NEW_IMAGE,
        WAIT_BUSY,
        WAIT_DONE,
        ADVANCE,
        GAP
    } seq_state_t;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        RAMP    = 2'd1,
        CHECKER = 2'd2,
        WALK    = 2'd3
    } pattern_t;

    localparam int FRAME_COUNT_W = 16;

    // Counter/index width for a bound; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/matrix_pattern_gen.sv
// rtl/matrix_pattern_gen.sv - combinational lane-byte generator; WALK and frame_count input exist only with MATRIX_SEQ_FRAME_COUNTER_EN
module matrix_pattern_gen
    import matrix_seq_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 3,
    parameter int SPI_SIZE       = 8,
    parameter int COLUMNS        = 16,
    parameter int COL_W          = 4,
    parameter int BYTE_W         = 5
) (
    input  pattern_t                                 mode,
    input  logic [SPI_SIZE-1:0]                      solid_value,
    input  logic [COL_W-1:0]                         col,
    input  logic [BYTE_W-1:0]                        byte_idx,
`ifdef MATRIX_SEQ_FRAME_COUNTER_EN
    input  logic [FRAME_COUNT_W-1:0]                 frame_count,
`endif
    output logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  lanes
);

    always_comb begin
        lanes = '0;
        for (int k = 0; k < CHANNEL_NUMBER; k++) begin
            case (mode)
                RAMP:    lanes[k] = SPI_SIZE'(int'(byte_idx) + k);
                CHECKER: lanes[k] = (((int'(col) ^ int'(byte_idx)) & 1) != 0) ? '1 : '0;
`ifdef MATRIX_SEQ_FRAME_COUNTER_EN
                WALK:    lanes[k] = (int'(col) == (int'(frame_count) % COLUMNS)) ? '1 : '0;
`endif
                default: lanes[k] = solid_value;
            endcase
        end
    end

endmodule

// File: rtl/matrix_frame_sequencer.sv
// rtl/matrix_frame_sequencer.sv - frame sequencer feeding output_module; MATRIX_SEQ_FRAME_COUNTER_EN adds frame_count and WALK
module matrix_frame_sequencer
    import matrix_seq_pkg::*;
#(
    parameter int CHANNEL_NUMBER   = 3,
    parameter int SPI_SIZE         = 8,
    parameter int COLUMNS          = 16,
    parameter int BYTES_PER_COLUMN = 24,
    parameter int FRAME_GAP        = 1000,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     enable,
    input  logic [1:0]                               mode,
    input  logic [SPI_SIZE-1:0]                      solid_value,
    input  logic                                     tx_finish,
    output logic                                     new_image,
    output logic                                     new_column,
    output logic                                     next_data,
    output logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  data_in,
    output logic                                     busy,
    output logic                                     error
`ifdef MATRIX_SEQ_FRAME_COUNTER_EN
    ,
    output logic [FRAME_COUNT_W-1:0]                 frame_count
`endif
);

    localparam int COL_W  = clog2_min1(COLUMNS);
    localparam int BYTE_W = clog2_min1(BYTES_PER_COLUMN);
    localparam int GAP_W  = clog2_min1(FRAME_GAP);
    localparam int WD_W   = clog2_min1(TIMEOUT_CYCLES);

    seq_state_t                                state, state_nxt;
    logic [COL_W-1:0]                          col_idx, col_nxt;
    logic [BYTE_W-1:0]                         byte_idx, byte_nxt;
    pattern_t                                  mode_q, mode_nxt;
    logic [SPI_SIZE-1:0]                       solid_q, solid_nxt;
    logic                                      pulse_img, pulse_col, pulse_data;
    logic [GAP_W-1:0]                          gap_cnt;
    logic [WD_W-1:0]                           wd_cnt;
    logic                                      in_wait, wd_expired, gap_done;
    logic                                      col_end, frame_end;
    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]   gen_lanes;

    assign in_wait    = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign wd_expired = in_wait && (int'(wd_cnt) >= TIMEOUT_CYCLES - 1);
    assign gap_done   = (int'(gap_cnt) >= FRAME_GAP - 1);
    assign col_end    = (byte_idx == BYTE_W'(BYTES_PER_COLUMN - 1));
    assign frame_end  = col_end && (col_idx == COL_W'(COLUMNS - 1));
    assign busy       = (state != IDLE);

    // Generator sees the index being issued, so data_in lands with its pulse.
    matrix_pattern_gen #(
        .CHANNEL_NUMBER (CHANNEL_NUMBER),
        .SPI_SIZE       (SPI_SIZE),
        .COLUMNS        (COLUMNS),
        .COL_W          (COL_W),
        .BYTE_W         (BYTE_W)
    ) u_pattern_gen (
        .mode        (mode_nxt),
        .solid_value (solid_nxt),
        .col         (col_nxt),
        .byte_idx    (byte_nxt),
`ifdef MATRIX_SEQ_FRAME_COUNTER_EN
        .frame_count (frame_count),
`endif
        .lanes       (gen_lanes)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        col_nxt    = col_idx;
        byte_nxt   = byte_idx;
        mode_nxt   = mode_q;
        solid_nxt  = solid_q;
        pulse_img  = 1'b0;
        pulse_col  = 1'b0;
        pulse_data = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = NEW_IMAGE;
            end
            NEW_IMAGE: begin
                mode_nxt  = pattern_t'(mode);
                solid_nxt = solid_value;
                col_nxt   = '0;
                byte_nxt  = '0;
                pulse_img = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wd_expired)      state_nxt = NEW_IMAGE;
                else if (!tx_finish) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (wd_expired)     state_nxt = NEW_IMAGE;
                else if (tx_finish) state_nxt = ADVANCE;
            end
            ADVANCE: begin
                if (frame_end) begin
                    state_nxt = GAP;
                end else begin
                    state_nxt = WAIT_BUSY;
                    if (col_end) begin
                        byte_nxt  = '0;
                        col_nxt   = col_idx + 1'b1;
                        pulse_col = 1'b1;
                    end else begin
                        byte_nxt   = byte_idx + 1'b1;
                        pulse_data = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_done) state_nxt = enable ? NEW_IMAGE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx    <= '0;
            byte_idx   <= '0;
            mode_q     <= SOLID;
            solid_q    <= '0;
            new_image  <= 1'b0;
            new_column <= 1'b0;
            next_data  <= 1'b0;
            data_in    <= '0;
            gap_cnt    <= '0;
            wd_cnt     <= '0;
            error      <= 1'b0;
        end else begin
            col_idx    <= col_nxt;
            byte_idx   <= byte_nxt;
            mode_q     <= mode_nxt;
            solid_q    <= solid_nxt;
            new_image  <= pulse_img;
            new_column <= pulse_col;
            next_data  <= pulse_data;
            if (pulse_img || pulse_col || pulse_data) data_in <= gen_lanes;

            if (state_nxt != state) wd_cnt <= '0;
            else if (in_wait)       wd_cnt <= wd_cnt + 1'b1;

            if (state_nxt != state)  gap_cnt <= '0;
            else if (state == GAP)   gap_cnt <= gap_cnt + 1'b1;

            if (wd_expired)                    error <= 1'b1;
            else if (state == IDLE && !enable) error <= 1'b0;
        end
    end

`ifdef MATRIX_SEQ_FRAME_COUNTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
        end else if (state == GAP && gap_done) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule
